imm_gen: RTL and testbench

Immediate generator for the RV32I datapath's decode stage. Given the 32-bit instruction word and a format select from the control unit, it extracts the immediate field and produces a sign-extended 32-bit value for the ALU operand mux and branch/jump target adders. The result is available combinationally and also as a registered copy for pipelined consumers.

---
 rtl/imm_gen_pkg.sv | 15 +
 rtl/imm_gen.sv | 45 ++++
 tb/tb_imm_gen.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/imm_gen_pkg.sv
// Shared decode constants for the RV32I control unit and immediate generator.
// The IMM_* codes are what the control unit drives onto imm_sel.
package imm_gen_pkg;

   localparam int unsigned XLEN      = 32;
   localparam int unsigned IMM_SEL_W = 3;

   // Immediate format select encodings
   localparam logic [IMM_SEL_W-1:0] IMM_I = 3'd0;
   localparam logic [IMM_SEL_W-1:0] IMM_S = 3'd1;
   localparam logic [IMM_SEL_W-1:0] IMM_B = 3'd2;
   localparam logic [IMM_SEL_W-1:0] IMM_U = 3'd3;
   localparam logic [IMM_SEL_W-1:0] IMM_J = 3'd4;

endpackage

// File: rtl/imm_gen.sv
// RV32I immediate generator. Extracts and sign-extends the immediate field of
// the instruction word according to imm_sel. The result is available both
// combinationally (imm_out) and as a one-cycle registered copy (imm_q).
// Codes 5..7 are unassigned: imm_out is forced to zero and sel_err is raised.
module imm_gen
   import imm_gen_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic [XLEN-1:0]      instr,
   input  logic [IMM_SEL_W-1:0] imm_sel,
   output logic [XLEN-1:0]      imm_out,
   output logic [XLEN-1:0]      imm_q,
   output logic                 sel_err
);

   // Decode the immediate field; sign bit is always instr[31]
   always_comb begin
      imm_out = '0;
      sel_err = 1'b0;
      case (imm_sel)
         IMM_I: imm_out = {{20{instr[31]}}, instr[31:20]};
         IMM_S: imm_out = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         IMM_B: imm_out = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                           instr[11:8], 1'b0};
         IMM_U: imm_out = {instr[31:12], 12'b0};
         IMM_J: imm_out = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                           instr[30:21], 1'b0};
         default: begin
            imm_out = '0;
            sel_err = 1'b1;
         end
      endcase
   end

   // Registered copy for pipelined consumers; cleared asynchronously by rst
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         imm_q <= '0;
      end else begin
         imm_q <= imm_out;
      end
   end

endmodule

// File: tb/tb_imm_gen.sv
// Self-checking bench for imm_gen: directed vectors from the RV32I encodings,
// registered-path and async-reset behaviour, then a random stream checked
// against an arithmetic-shift reference model through a scoreboard.
module tb_imm_gen;
   import imm_gen_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] instr;
   logic [2:0]  imm_sel;
   logic [31:0] imm_out;
   logic [31:0] imm_q;
   logic        sel_err;

   typedef struct {
      string       tag;
      logic [31:0] imm;
      logic        err;
   } exp_t;

   exp_t comb_q[$];
   exp_t reg_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   imm_gen dut (
      .clk     (clk),
      .rst     (rst),
      .instr   (instr),
      .imm_sel (imm_sel),
      .imm_out (imm_out),
      .imm_q   (imm_q),
      .sel_err (sel_err)
   );

   always #5 clk = ~clk;

   // Reference model: reassemble each field at the top of a signed word and
   // arithmetic-shift it down, so sign extension comes from >>> not replication
   function automatic logic [31:0] ref_imm(input logic [2:0] s, input logic [31:0] w);
      logic signed [31:0] t;
      logic [31:0]        r;
      r = '0;
      case (s)
         3'd0: begin
            t = w;
            t = t >>> 20;
            r = t;
         end
         3'd1: begin
            t = w;
            t = t >>> 25;
            r = (t << 5) | {27'b0, w[11:7]};
         end
         3'd2: begin
            t = {w[31], w[7], w[30:25], w[11:8], 1'b0, 19'b0};
            t = t >>> 19;
            r = t;
         end
         3'd3: r = w & 32'hFFFF_F000;
         3'd4: begin
            t = {w[31], w[19:12], w[20], w[30:21], 1'b0, 11'b0};
            t = t >>> 11;
            r = t;
         end
         default: r = '0;
      endcase
      return r;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   // Drive a directed vector with a hand-derived expectation
   task automatic drive_dir(input logic [2:0] s, input logic [31:0] w,
                            input logic [31:0] e_imm, input logic e_err, input string tag);
      exp_t e;
      imm_sel = s;
      instr   = w;
      e.tag = tag;
      e.imm = e_imm;
      e.err = e_err;
      comb_q.push_back(e);
   endtask

   // Drive a vector whose expectation comes from the reference model
   task automatic drive_ref(input logic [2:0] s, input logic [31:0] w, input string tag,
                            input bit to_reg);
      exp_t e;
      imm_sel = s;
      instr   = w;
      e.tag = tag;
      e.imm = ref_imm(s, w);
      e.err = (s > 3'd4);
      comb_q.push_back(e);
      if (to_reg) reg_q.push_back(e);
   endtask

   task automatic pop_comb();
      exp_t e;
      #1;
      if (comb_q.size() == 0) begin
         check("comb_q_empty", 32'd1, 32'd0);
      end else begin
         e = comb_q.pop_front();
         check({e.tag, "_imm"}, imm_out, e.imm);
         check({e.tag, "_err"}, {31'b0, sel_err}, {31'b0, e.err});
      end
   endtask

   // Wait for the capturing edge, then compare imm_q against the oldest entry
   task automatic pop_reg();
      exp_t e;
      @(posedge clk);
      #1;
      if (reg_q.size() == 0) begin
         check("reg_q_empty", 32'd1, 32'd0);
      end else begin
         e = reg_q.pop_front();
         check({e.tag, "_q"}, imm_q, e.imm);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      exp_t e;
      rst     = 1'b1;
      instr   = '0;
      imm_sel = IMM_I;
      #1;
      check("rst_imm_q", imm_q, 32'h0);

      // Combinational path works while rst is held
      drive_dir(IMM_I, 32'h00A0_0613, 32'd10,        1'b0, "i_pos");   pop_comb();
      drive_dir(IMM_I, 32'hFFF0_0093, 32'hFFFF_FFFF, 1'b0, "i_neg");   pop_comb();
      drive_dir(IMM_B, 32'h0006_0C63, 32'd24,        1'b0, "b_pos");   pop_comb();
      drive_dir(IMM_B, 32'hFE00_0EE3, 32'hFFFF_FFFC, 1'b0, "b_neg");   pop_comb();
      drive_dir(IMM_J, 32'hFEDF_F06F, 32'hFFFF_FFEC, 1'b0, "j_neg");   pop_comb();
      drive_dir(IMM_J, 32'h0140_006F, 32'd20,        1'b0, "j_pos");   pop_comb();
      drive_dir(IMM_S, 32'hFE11_2E23, 32'hFFFF_FFFC, 1'b0, "s_neg");   pop_comb();
      drive_dir(IMM_U, 32'h1234_52B7, 32'h1234_5000, 1'b0, "u");       pop_comb();
      drive_dir(3'd5,  32'hFFFF_FFFF, 32'h0,         1'b1, "sel5");    pop_comb();
      drive_dir(3'd6,  32'h8000_0000, 32'h0,         1'b1, "sel6");    pop_comb();
      drive_dir(3'd7,  32'h1234_52B7, 32'h0,         1'b1, "sel7");    pop_comb();

      // imm_q stays cleared across an edge while rst is held
      @(posedge clk);
      #1;
      check("rst_hold_q", imm_q, 32'h0);

      // Release reset; first capture on the next rising edge
      @(negedge clk);
      rst = 1'b0;
      drive_dir(IMM_I, 32'h00A0_0613, 32'd10, 1'b0, "i_rel");
      e = comb_q[0];
      reg_q.push_back(e);
      pop_comb();
      check("pre_edge_q", imm_q, 32'h0);
      pop_reg();

      // New input mid-cycle: imm_q holds until the following edge
      @(negedge clk);
      drive_ref(IMM_I, 32'hFFF0_0093, "i_neg_reg", 1'b1);
      pop_comb();
      check("hold_q", imm_q, 32'd10);
      pop_reg();

      // Async reset mid-cycle clears imm_q without a clock edge
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("async_rst_q", imm_q, 32'h0);
      @(posedge clk);
      #1;
      check("async_rst_hold_q", imm_q, 32'h0);
      @(negedge clk);
      rst = 1'b0;

      // Random back-to-back stream through both paths
      for (int i = 0; i < 24; i++) begin
         if (i != 0) @(negedge clk);
         drive_ref(3'($urandom_range(0, 7)), $urandom, $sformatf("rnd%0d", i), 1'b1);
         pop_comb();
         pop_reg();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
